jtag_tap_multichain: RTL and testbench
======================================

Name: jtag_tap_multichain

Overview:
Parametrised, single-clock JTAG TAP controller with N selectable boundary-scan chains. Replaces the fixed two-chain arrangement. Adds a full 16-state TAP, an internal IDCODE register, a true 1-bit BYPASS register and INTEST/EXTEST distinction. Chains stay external and are driven by per-chain enables and one-cycle strobes. All logic runs on clk (TCK), so there are no gated clocks.

Parameters:
CHAIN_NUM, 4, number of external boundary-scan chains (>=1)
SEL_W, $clog2(CHAIN_NUM) (min 1), chain-select field width
IR_WIDTH, SEL_W+3, instruction register width: {sel[SEL_W-1:0], op[2:0]}
IDCODE_VALUE, 32'h1ABC_D001, device ID; bit0 must be 1

Ports:
clk  in  1  TCK; all state updates on posedge
reset  in  1  synchronous, active-high
tms_i  in  1  test mode select
tdi_i  in  1  test data in
tdo_o  out  1  test data out
tdo_en_o  out  1  high only in Shift-IR / Shift-DR
tap_state_o  out  4  current TAP state encoding
instr_o  out  IR_WIDTH  active (updated) instruction
chain_en_o  out  CHAIN_NUM  one-hot selected chain; all zero when no chain is active
capture_dr_o  out  1  chain capture strobe
shift_dr_o  out  1  chain shift enable
update_dr_o  out  1  chain update strobe
bsc_mode_o  out  1  1 = cells drive parallel outs from update latch (EXTEST/INTEST)
intest_o  out  1  1 = INTEST active
chain_so_i  in  CHAIN_NUM  serial outputs of the chains

Behaviour:
- TAP: standard IEEE 1149.1 16-state graph. The state register advances on posedge clk using tms_i.
- Opcodes (op field): 000 EXTEST, 001 SAMPLE_PRELOAD, 010 INTEST, 011 IDCODE, 111 BYPASS. All other opcodes decode as BYPASS.
- chain_active = op in {EXTEST, SAMPLE_PRELOAD, INTEST} and sel < CHAIN_NUM. If sel >= CHAIN_NUM, the instruction behaves as BYPASS.
- Reset (reset=1 at posedge):
  - state = TEST_LOGIC_RESET; instr = {0, IDCODE}; IR shift reg = 0; bypass reg = 0; idcode shift reg = IDCODE_VALUE.
  - All strobes 0, tdo_en_o = 0, bsc_mode_o = 0.
- While in TEST_LOGIC_RESET, instr is forced to IDCODE every cycle. Reset mid-shift aborts immediately with no update.
- IR path:
  - CAPTURE_IR: shift reg loads {0..0,2'b01}.
  - SHIFT_IR: shift right, tdi_i enters the MSB.
  - UPDATE_IR: instr <= shift reg.
- DR path, selected by the decoded instruction:
  - BYPASS: 1-bit reg. Capture loads 0; shift loads tdi_i.
  - IDCODE: 32-bit reg. Capture loads IDCODE_VALUE; shift is right-shift with tdi_i in the MSB.
  - Chain instruction: strobes go to the external chains.
- Strobes (combinational from the registered state, gated by chain_active):
  - capture_dr_o = CAPTURE_DR; shift_dr_o = SHIFT_DR; update_dr_o = UPDATE_DR.
  - Each strobe lasts exactly one clk per state visit. shift_dr_o stays high for every cycle spent in SHIFT_DR.
- chain_en_o: one-hot of sel when chain_active, else 0.
- bsc_mode_o / intest_o: registered, updated at the UPDATE_IR edge.
  - bsc_mode_o = 1 for EXTEST or INTEST, else 0. No toggling.
  - Cleared on reset and on TEST_LOGIC_RESET entry.
- tdo_o (combinational):
  - SHIFT_IR: IR shift reg LSB.
  - SHIFT_DR: the LSB of the selected DR (chain_so_i[sel], idcode LSB or bypass bit).
  - Otherwise 0, with tdo_en_o = 0.
- tap_state_o: package encoding, registered state.
- Pause/Exit2 loops hold shift contents. Re-entering SHIFT without passing CAPTURE continues the shift.

Decomposition:
- Package jtag_pkg:
  - tap_state_t enum (IEEE 4-bit encodings: TLR=F, RTI=C, SELDR=7, CAPDR=6, SHDR=2, EX1DR=1, PDR=3, EX2DR=0, UPDR=5, SELIR=4, CAPIR=E, SHIR=A, EX1IR=9, PIR=B, EX2IR=8, UPIR=D).
  - opcode localparams.
- Sub-module jtag_tap_fsm: state register plus next-state logic, ports clk/reset/tms_i/state.
- Everything else lives in the top.

Test Plan:
1. reset=1 for 2 cycles, then tms_i=0 -> tap_state_o=C (RTI), instr_o op=011, all strobes 0, tdo_en_o=0.
2. From RTI, go to SHIFT_DR and shift 32 bits with tdi_i=0 -> tdo_o sequence LSB-first = 32'h1ABC_D001.
3. Shift IR 5'b10_111 (BYPASS), then in SHIFT_DR drive tdi_i pattern 1,0,1,1 -> tdo_o = 0,1,0,1 (one-cycle delay); chain_en_o=0.
4. Load IR {sel=2, EXTEST}. Capture-IR shift-out -> first 2 tdo bits 1,0. After UPDATE_IR: chain_en_o=4'b0100, bsc_mode_o=1, intest_o=0. SHIFT_DR for 6 cycles -> shift_dr_o high 6 cycles, tdo_o tracks chain_so_i[2]; capture_dr_o and update_dr_o each pulse exactly once.
5. Load IR {sel=1, SAMPLE_PRELOAD} -> bsc_mode_o=0, chain_en_o=4'b0010. Then {sel=1, INTEST} -> bsc_mode_o=1, intest_o=1. Invalid op 101 -> behaves as BYPASS, strobes 0.
6. Assert reset mid-SHIFT_DR with EXTEST active -> next cycle state F, instr op=011, bsc_mode_o=0, no update_dr_o pulse. Also from any state, 5× tms_i=1 -> TLR.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared definitions for the multichain JTAG TAP: state encodings,
// instruction opcodes and a small opcode classification helper.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'hF,
    RUN_TEST_IDLE    = 4'hC,
    SELECT_DR        = 4'h7,
    CAPTURE_DR       = 4'h6,
    SHIFT_DR         = 4'h2,
    EXIT1_DR         = 4'h1,
    PAUSE_DR         = 4'h3,
    EXIT2_DR         = 4'h0,
    UPDATE_DR        = 4'h5,
    SELECT_IR        = 4'h4,
    CAPTURE_IR       = 4'hE,
    SHIFT_IR         = 4'hA,
    EXIT1_IR         = 4'h9,
    PAUSE_IR         = 4'hB,
    EXIT2_IR         = 4'h8,
    UPDATE_IR        = 4'hD
  } tap_state_t;

  localparam logic [2:0] OP_EXTEST         = 3'b000;
  localparam logic [2:0] OP_SAMPLE_PRELOAD = 3'b001;
  localparam logic [2:0] OP_INTEST         = 3'b010;
  localparam logic [2:0] OP_IDCODE         = 3'b011;
  localparam logic [2:0] OP_BYPASS         = 3'b111;

  function automatic logic is_chain_op(input logic [2:0] op);
    return (op == OP_EXTEST) || (op == OP_SAMPLE_PRELOAD) || (op == OP_INTEST);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller state machine, advanced on every
// clk edge by tms_i.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tms_i,
  output tap_state_t state_o
);

  tap_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= TEST_LOGIC_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TEST_LOGIC_RESET: state_d = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_d = tms_i ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = tms_i ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = tms_i ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = tms_i ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_d = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = tms_i ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = tms_i ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = tms_i ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
      default:          state_d = TEST_LOGIC_RESET;
    endcase
  end

  always_comb begin
    state_o = state_q;
  end

endmodule

// File: rtl/jtag_tap_multichain.sv
// JTAG TAP with internal IDCODE/BYPASS registers and strobes/enables for
// CHAIN_NUM external boundary-scan chains, all on a single clock.
module jtag_tap_multichain
  import jtag_pkg::*;
#(
  parameter int          CHAIN_NUM    = 4,
  parameter int          SEL_W        = (CHAIN_NUM > 1) ? $clog2(CHAIN_NUM) : 1,
  parameter int          IR_WIDTH     = SEL_W + 3,
  parameter logic [31:0] IDCODE_VALUE = 32'h1ABC_D001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tms_i,
  input  logic                 tdi_i,
  output logic                 tdo_o,
  output logic                 tdo_en_o,
  output logic [3:0]           tap_state_o,
  output logic [IR_WIDTH-1:0]  instr_o,
  output logic [CHAIN_NUM-1:0] chain_en_o,
  output logic                 capture_dr_o,
  output logic                 shift_dr_o,
  output logic                 update_dr_o,
  output logic                 bsc_mode_o,
  output logic                 intest_o,
  input  logic [CHAIN_NUM-1:0] chain_so_i
);

  localparam logic [IR_WIDTH-1:0] INSTR_IDCODE = {{SEL_W{1'b0}}, OP_IDCODE};

  tap_state_t state_q;

  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         idcode_q, idcode_d;
  logic                bsc_mode_q, bsc_mode_d;
  logic                intest_q, intest_d;

  logic [2:0]       op, new_op;
  logic [SEL_W-1:0] sel, new_sel;
  logic             sel_valid, new_sel_valid;
  logic             chain_active, idcode_sel, bypass_sel, tlr_entry;

  jtag_tap_fsm u_fsm (
    .clk     (clk),
    .reset   (reset),
    .tms_i   (tms_i),
    .state_o (state_q)
  );

  // Decode of the active instruction and of the one about to be updated.
  always_comb begin
    op            = instr_q[2:0];
    sel           = instr_q[IR_WIDTH-1:3];
    new_op        = ir_shift_q[2:0];
    new_sel       = ir_shift_q[IR_WIDTH-1:3];
    sel_valid     = ({1'b0, sel} < (SEL_W+1)'(CHAIN_NUM));
    new_sel_valid = ({1'b0, new_sel} < (SEL_W+1)'(CHAIN_NUM));
    chain_active  = is_chain_op(op) && sel_valid;
    idcode_sel    = (op == OP_IDCODE);
    bypass_sel    = !chain_active && !idcode_sel;
    tlr_entry     = (state_q == TEST_LOGIC_RESET) || ((state_q == SELECT_IR) && tms_i);
  end

  always_comb begin
    ir_shift_d = ir_shift_q;
    instr_d    = instr_q;
    bypass_d   = bypass_q;
    idcode_d   = idcode_q;
    bsc_mode_d = bsc_mode_q;
    intest_d   = intest_q;
    case (state_q)
      CAPTURE_IR: ir_shift_d = IR_WIDTH'(2'b01);
      SHIFT_IR:   ir_shift_d = {tdi_i, ir_shift_q[IR_WIDTH-1:1]};
      UPDATE_IR: begin
        instr_d    = ir_shift_q;
        bsc_mode_d = new_sel_valid && ((new_op == OP_EXTEST) || (new_op == OP_INTEST));
        intest_d   = new_sel_valid && (new_op == OP_INTEST);
      end
      CAPTURE_DR: begin
        if (idcode_sel) idcode_d = IDCODE_VALUE;
        if (bypass_sel) bypass_d = 1'b0;
      end
      SHIFT_DR: begin
        if (idcode_sel) idcode_d = {tdi_i, idcode_q[31:1]};
        if (bypass_sel) bypass_d = tdi_i;
      end
      default: ;
    endcase
    // Entering or sitting in Test-Logic-Reset forces IDCODE and drops cell mode.
    if (tlr_entry) begin
      instr_d    = INSTR_IDCODE;
      bsc_mode_d = 1'b0;
      intest_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_shift_q <= '0;
      instr_q    <= INSTR_IDCODE;
      bypass_q   <= 1'b0;
      idcode_q   <= IDCODE_VALUE;
      bsc_mode_q <= 1'b0;
      intest_q   <= 1'b0;
    end else begin
      ir_shift_q <= ir_shift_d;
      instr_q    <= instr_d;
      bypass_q   <= bypass_d;
      idcode_q   <= idcode_d;
      bsc_mode_q <= bsc_mode_d;
      intest_q   <= intest_d;
    end
  end

  always_comb begin
    tap_state_o  = state_q;
    instr_o      = instr_q;
    bsc_mode_o   = bsc_mode_q;
    intest_o     = intest_q;
    capture_dr_o = chain_active && (state_q == CAPTURE_DR);
    shift_dr_o   = chain_active && (state_q == SHIFT_DR);
    update_dr_o  = chain_active && (state_q == UPDATE_DR);
    chain_en_o   = chain_active ? (CHAIN_NUM'(1) << sel) : '0;
    tdo_en_o     = (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
    tdo_o        = 1'b0;
    if (state_q == SHIFT_IR) begin
      tdo_o = ir_shift_q[0];
    end else if (state_q == SHIFT_DR) begin
      if (chain_active)    tdo_o = chain_so_i[sel];
      else if (idcode_sel) tdo_o = idcode_q[0];
      else                 tdo_o = bypass_q;
    end
  end

endmodule

// File: tb/tb_jtag_tap_multichain.sv
// Directed bench for jtag_tap_multichain: reset, IDCODE, BYPASS, chain
// instructions, invalid opcode, mid-shift reset and TMS-driven reset.
module tb_jtag_tap_multichain;

  localparam int CHAIN_NUM = 4;
  localparam int IR_WIDTH  = 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 tmsIn = 1'b0;
  logic                 tdiIn = 1'b0;
  logic                 tdoOut;
  logic                 tdoEnOut;
  logic [3:0]           tapState;
  logic [IR_WIDTH-1:0]  instrOut;
  logic [CHAIN_NUM-1:0] chainEn;
  logic                 captureDr, shiftDr, updateDr;
  logic                 bscMode, intestOut;
  logic [CHAIN_NUM-1:0] chainSo = '0;

  int checks = 0;
  int errors = 0;

  // Strobe pulse counters, sampled mid-cycle and cleared on request.
  logic cntClear = 1'b1;
  int   capCnt, shCnt, upCnt;

  logic [IR_WIDTH-1:0] irOut;
  logic [31:0]         drOut;

  jtag_tap_multichain #(.CHAIN_NUM(CHAIN_NUM)) dut (
    .clk          (clk),
    .reset        (reset),
    .tms_i        (tmsIn),
    .tdi_i        (tdiIn),
    .tdo_o        (tdoOut),
    .tdo_en_o     (tdoEnOut),
    .tap_state_o  (tapState),
    .instr_o      (instrOut),
    .chain_en_o   (chainEn),
    .capture_dr_o (captureDr),
    .shift_dr_o   (shiftDr),
    .update_dr_o  (updateDr),
    .bsc_mode_o   (bscMode),
    .intest_o     (intestOut),
    .chain_so_i   (chainSo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cntClear) begin
      capCnt <= 0;
      shCnt  <= 0;
      upCnt  <= 0;
    end else begin
      capCnt <= capCnt + int'(captureDr);
      shCnt  <= shCnt + int'(shiftDr);
      upCnt  <= upCnt + int'(updateDr);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic tms, input logic tdi);
    tmsIn = tms;
    tdiIn = tdi;
    @(posedge clk);
    #1;
  endtask

  task automatic clearCounters();
    cntClear = 1'b1;
    @(negedge clk);
    #1;
    cntClear = 1'b0;
  endtask

  // From Run-Test/Idle: load an instruction, return to Run-Test/Idle.
  task automatic loadIr(input logic [IR_WIDTH-1:0] bits, output logic [IR_WIDTH-1:0] tdoBits);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    for (int i = 0; i < IR_WIDTH; i++) begin
      tdoBits[i] = tdoOut;
      applyStimulus(i == IR_WIDTH - 1, bits[i]);
    end
    applyStimulus(1, 0);
    applyStimulus(0, 0);
  endtask

  // From Run-Test/Idle: shift n DR bits LSB first, return to Run-Test/Idle.
  // Chain bit for cycle i is soBits[i] on chain 2 and its inverse elsewhere.
  task automatic shiftDrBits(input int n, input logic [31:0] tdiBits, input logic [31:0] soBits,
                             output logic [31:0] tdoBits);
    tdoBits = '0;
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    for (int i = 0; i < n; i++) begin
      chainSo = soBits[i] ? 4'b0100 : 4'b1011;
      #1;
      tdoBits[i] = tdoOut;
      applyStimulus(i == n - 1, tdiBits[i]);
    end
    applyStimulus(1, 0);
    applyStimulus(0, 0);
  endtask

  initial begin
    // Reset and enter Run-Test/Idle
    reset = 1'b1;
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    reset = 1'b0;
    applyStimulus(0, 0);
    checkOutput("rti_state", 32'(tapState), 32'hC);
    checkOutput("reset_instr", 32'(instrOut), 32'h03);
    checkOutput("reset_strobes", {29'd0, captureDr, shiftDr, updateDr}, 32'h0);
    checkOutput("reset_tdo_en", 32'(tdoEnOut), 32'h0);
    checkOutput("reset_bsc", {30'd0, bscMode, intestOut}, 32'h0);
    checkOutput("reset_chain_en", 32'(chainEn), 32'h0);

    // IDCODE readout
    shiftDrBits(32, 32'h0, 32'h0, drOut);
    checkOutput("idcode_out", drOut, 32'h1ABC_D001);

    // BYPASS: one-cycle delay through the bypass bit
    loadIr(5'b10_111, irOut);
    checkOutput("bypass_instr", 32'(instrOut), 32'h17);
    checkOutput("bypass_chain_en", 32'(chainEn), 32'h0);
    shiftDrBits(4, 32'b1101, 32'h0, drOut);
    checkOutput("bypass_tdo", drOut, 32'b1010);

    // EXTEST on chain 2
    loadIr({2'd2, 3'b000}, irOut);
    checkOutput("capture_ir_bits", 32'(irOut[1:0]), 32'b01);
    checkOutput("extest_chain_en", 32'(chainEn), 32'b0100);
    checkOutput("extest_bsc", {30'd0, bscMode, intestOut}, 32'b10);
    clearCounters();
    shiftDrBits(6, 32'h0, 32'b101100, drOut);
    checkOutput("extest_tdo_chain2", drOut, 32'b101100);
    checkOutput("extest_capture_cnt", 32'(capCnt), 32'd1);
    checkOutput("extest_shift_cnt", 32'(shCnt), 32'd6);
    checkOutput("extest_update_cnt", 32'(upCnt), 32'd1);

    // SAMPLE_PRELOAD, INTEST and an undefined opcode on chain 1
    loadIr({2'd1, 3'b001}, irOut);
    checkOutput("sample_chain_en", 32'(chainEn), 32'b0010);
    checkOutput("sample_bsc", {30'd0, bscMode, intestOut}, 32'b00);
    loadIr({2'd1, 3'b010}, irOut);
    checkOutput("intest_chain_en", 32'(chainEn), 32'b0010);
    checkOutput("intest_bsc", {30'd0, bscMode, intestOut}, 32'b11);
    loadIr({2'd1, 3'b101}, irOut);
    checkOutput("badop_chain_en", 32'(chainEn), 32'h0);
    checkOutput("badop_bsc", {30'd0, bscMode, intestOut}, 32'b00);
    clearCounters();
    shiftDrBits(2, 32'b11, 32'b11, drOut);
    checkOutput("badop_tdo", drOut, 32'b10);
    checkOutput("badop_strobes", 32'(capCnt + shCnt + upCnt), 32'd0);

    // Reset in the middle of an EXTEST shift
    loadIr({2'd0, 3'b000}, irOut);
    checkOutput("extest0_bsc", 32'(bscMode), 32'h1);
    clearCounters();
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    checkOutput("midshift_state", 32'(tapState), 32'h2);
    reset = 1'b1;
    applyStimulus(0, 0);
    checkOutput("midreset_state", 32'(tapState), 32'hF);
    checkOutput("midreset_op", 32'(instrOut[2:0]), 32'h3);
    checkOutput("midreset_bsc", 32'(bscMode), 32'h0);
    checkOutput("midreset_update_cnt", 32'(upCnt), 32'd0);
    reset = 1'b0;
    applyStimulus(0, 0);
    checkOutput("post_reset_rti", 32'(tapState), 32'hC);

    // Five TMS highs from Shift-IR land in Test-Logic-Reset
    loadIr({2'd3, 3'b010}, irOut);
    checkOutput("intest3_bsc", {30'd0, bscMode, intestOut}, 32'b11);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("shift_ir_state", 32'(tapState), 32'hA);
    checkOutput("shift_ir_tdo_en", 32'(tdoEnOut), 32'h1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0);
    checkOutput("tms_tlr_state", 32'(tapState), 32'hF);
    checkOutput("tms_tlr_instr", 32'(instrOut), 32'h03);
    checkOutput("tms_tlr_bsc", {30'd0, bscMode, intestOut}, 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
